// File: rtl/lsu_regs_port.sv
// Multi-cycle RV32I load/store unit attached to the register file's memory-side
// ports. Accepts one decoded memory op at a time, runs a valid/ready bus
// transaction, and writes extended load data back through the memory write port.
//
// state | meaning
// IDLE  | ready for a new instruction; illegal/misaligned ops are rejected here
// REQ   | bus request held stable until mem_req_ready_i
// RWAIT | load issued, waiting for mem_rvalid_i
// WB    | load data ready, waiting for the writeback port to be free
module lsu_regs_port #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   base_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    output logic [REG_AW-1:0] reg_read_addr_o,
    input  logic [XLEN-1:0]   reg_read_data_i,
    output logic              reg_write_en_o,
    output logic [REG_AW-1:0] reg_write_addr_o,
    output logic [XLEN-1:0]   reg_write_data_o,
    input  logic              wb_block_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              done_o,
    output logic              err_o,
    output logic [XLEN-1:0]   err_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RWAIT = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [XLEN-1:0]     mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_wstrb_q, mem_wstrb_d;
    logic [REG_AW-1:0]   reg_write_addr_q, reg_write_addr_d;
    logic [XLEN-1:0]     reg_write_data_q, reg_write_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [XLEN-1:0]     err_addr_q, err_addr_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;

    logic [XLEN-1:0]     ea;
    logic                legal;
    logic                misalign;
    logic [XLEN-1:0]     st_wdata;
    logic [3:0]          st_wstrb;
    logic [XLEN-1:0]     rdata_sh;
    logic [15:0]         ld_half;
    logic [XLEN-1:0]     ld_ext;
    logic                wb_fire;

    // Effective address, legality, alignment and store lane formatting for the offered op.
    always_comb begin
        ea = base_i + imm_i;
        if (is_store_i) begin
            legal = (funct3_i == 3'd0) || (funct3_i == 3'd1) || (funct3_i == 3'd2);
        end else begin
            legal = (funct3_i == 3'd0) || (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                    (funct3_i == 3'd4) || (funct3_i == 3'd5);
        end
        misalign = ((funct3_i[1:0] == 2'd1) && ea[0]) ||
                   ((funct3_i[1:0] == 2'd2) && (ea[1:0] != 2'b00));
        case (funct3_i[1:0])
            2'd0: begin
                st_wdata = {4{reg_read_data_i[7:0]}};
                st_wstrb = 4'b0001 << ea[1:0];
            end
            2'd1: begin
                st_wdata = {2{reg_read_data_i[15:0]}};
                st_wstrb = ea[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = reg_read_data_i;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension using the captured offset and width.
    always_comb begin
        rdata_sh = mem_rdata_i >> {off_q, 3'b000};
        ld_half  = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'd0:    ld_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_ext = {24'h0, rdata_sh[7:0]};
            3'd5:    ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        mem_req_valid_d  = mem_req_valid_q;
        mem_we_d         = mem_we_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        mem_wstrb_d      = mem_wstrb_q;
        reg_write_addr_d = reg_write_addr_q;
        reg_write_data_d = reg_write_data_q;
        done_d           = 1'b0;
        err_d            = 1'b0;
        err_addr_d       = err_addr_q;
        funct3_d         = funct3_q;
        off_d            = off_q;
        case (state_q)
            S_IDLE: begin
                if (issue_valid_i) begin
                    if (!legal || misalign) begin
                        done_d     = 1'b1;
                        err_d      = 1'b1;
                        err_addr_d = ea;
                    end else begin
                        state_d         = S_REQ;
                        mem_req_valid_d = 1'b1;
                        mem_we_d        = is_store_i;
                        mem_addr_d      = {ea[31:2], 2'b00};
                        mem_wdata_d     = is_store_i ? st_wdata : '0;
                        mem_wstrb_d     = is_store_i ? st_wstrb : 4'b0000;
                        funct3_d        = funct3_i;
                        off_d           = ea[1:0];
                        if (!is_store_i) begin
                            reg_write_addr_d = rd_addr_i;
                        end
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    mem_req_valid_d = 1'b0;
                    mem_we_d        = 1'b0;
                    mem_wstrb_d     = 4'b0000;
                    if (mem_we_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RWAIT;
                    end
                end
            end
            S_RWAIT: begin
                if (mem_rvalid_i) begin
                    reg_write_data_d = ld_ext;
                    state_d          = S_WB;
                end
            end
            S_WB: begin
                if (!wb_block_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously so a reset drops any bus request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            mem_req_valid_q  <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_wstrb_q      <= 4'b0000;
            reg_write_addr_q <= '0;
            reg_write_data_q <= '0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            err_addr_q       <= '0;
            funct3_q         <= 3'd0;
            off_q            <= 2'd0;
        end else begin
            state_q          <= state_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_wstrb_q      <= mem_wstrb_d;
            reg_write_addr_q <= reg_write_addr_d;
            reg_write_data_q <= reg_write_data_d;
            done_q           <= done_d;
            err_q            <= err_d;
            err_addr_q       <= err_addr_d;
            funct3_q         <= funct3_d;
            off_q            <= off_d;
        end
    end

    // The writeback port is arbitrated in the same cycle as the write, so the
    // WB-cycle write enable and its done are gated by the current wb_block_i
    // directly from the state register rather than being decided a cycle early.
    always_comb begin
        wb_fire        = (state_q == S_WB) && !wb_block_i;
        reg_write_en_o = wb_fire && (reg_write_addr_q != '0);
        done_o         = done_q | wb_fire;
    end

    assign issue_ready_o    = (state_q == S_IDLE);
    assign reg_read_addr_o  = rs2_addr_i;
    assign reg_write_addr_o = reg_write_addr_q;
    assign reg_write_data_o = reg_write_data_q;
    assign mem_req_valid_o  = mem_req_valid_q;
    assign mem_we_o         = mem_we_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign mem_wstrb_o      = mem_wstrb_q;
    assign err_o            = err_q;
    assign err_addr_o       = err_addr_q;

endmodule

// File: tb/tb_lsu_regs_port.sv
// Directed bench for lsu_regs_port: loads, stores, misalignment, writeback
// contention, reset mid-transaction and back-to-back issue.
module tb_lsu_regs_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready, is_store;
    logic [2:0]  funct3;
    logic [31:0] base, imm;
    logic [4:0]  rs2_addr, rd_addr, reg_read_addr, reg_write_addr;
    logic [31:0] reg_read_data, reg_write_data;
    logic        reg_write_en, wb_block;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        done, err;
    logic [31:0] err_addr;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lsu_regs_port #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .is_store_i(is_store), .funct3_i(funct3), .base_i(base), .imm_i(imm),
        .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr),
        .reg_read_addr_o(reg_read_addr), .reg_read_data_i(reg_read_data),
        .reg_write_en_o(reg_write_en), .reg_write_addr_o(reg_write_addr),
        .reg_write_data_o(reg_write_data), .wb_block_i(wb_block),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .done_o(done), .err_o(err), .err_addr_o(err_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] im, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] sdata);
        is_store      = st;
        funct3        = f3;
        base          = b;
        imm           = im;
        rs2_addr      = rs2;
        rd_addr       = rd;
        reg_read_data = sdata;
        issue_valid   = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if ({mem_req_valid, mem_we, reg_write_en, done, err, issue_ready} !== 6'b000001)
            $display("FAIL reset_ctrl: got %b expected 000001",
                     {mem_req_valid, mem_we, reg_write_en, done, err, issue_ready});
        else n_pass++;
        n_total++;
        if ({mem_addr, mem_wdata, mem_wstrb, reg_write_addr, reg_write_data, err_addr} !== '0)
            $display("FAIL reset_data: addr %h wdata %h wstrb %b wa %h wd %h ea %h expected all 0",
                     mem_addr, mem_wdata, mem_wstrb, reg_write_addr, reg_write_data, err_addr);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic run_load(input string nm, input logic [2:0] f3, input logic [31:0] b,
                            input logic [31:0] im, input logic [4:0] rd, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data);
        logic exp_we;
        exp_we = (rd != 5'd0);
        issue(1'b0, f3, b, im, 5'd0, rd, 32'h0);
        mem_req_ready = 1'b1;
        n_total++;
        if (issue_ready !== 1'b1) $display("FAIL %s_issue_ready: got %b expected 1", nm, issue_ready);
        else n_pass++;
        tick();  // T1
        issue_valid = 1'b0;
        n_total++;
        if ({mem_req_valid, mem_we, mem_wstrb, done, mem_addr} !== {1'b1, 1'b0, 4'b0000, 1'b0, exp_addr})
            $display("FAIL %s_req: valid %b we %b wstrb %b done %b addr %h expected 1 0 0000 0 %h",
                     nm, mem_req_valid, mem_we, mem_wstrb, done, mem_addr, exp_addr);
        else n_pass++;
        tick();  // T2
        n_total++;
        if ({mem_req_valid, reg_write_en, done} !== 3'b000)
            $display("FAIL %s_rwait: valid %b wen %b done %b expected 000", nm, mem_req_valid, reg_write_en, done);
        else n_pass++;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();  // T3
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        n_total++;
        if ({reg_write_en, done, err, reg_write_addr, reg_write_data} !== {exp_we, 1'b1, 1'b0, rd, exp_data})
            $display("FAIL %s_wb: wen %b done %b err %b waddr %0d wdata %h expected %b 1 0 %0d %h",
                     nm, reg_write_en, done, err, reg_write_addr, reg_write_data, exp_we, rd, exp_data);
        else n_pass++;
        tick();  // T4
        n_total++;
        if ({reg_write_en, done, issue_ready} !== 3'b001)
            $display("FAIL %s_after: wen %b done %b ready %b expected 001", nm, reg_write_en, done, issue_ready);
        else n_pass++;
    endtask

    task automatic run_store(input string nm, input logic [2:0] f3, input logic [31:0] b,
                             input logic [31:0] im, input logic [31:0] sdata, input int waitn,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_wstrb);
        issue(1'b1, f3, b, im, 5'd9, 5'd3, sdata);
        mem_req_ready = 1'b0;
        #1;
        n_total++;
        if (reg_read_addr !== 5'd9) $display("FAIL %s_rdaddr: got %0d expected 9", nm, reg_read_addr);
        else n_pass++;
        tick();  // T1
        reg_read_data = 32'h0;
        base          = 32'h0000_FFF0;
        for (int i = 0; i <= waitn; i++) begin
            issue_valid   = (i < waitn);
            mem_req_ready = (i == waitn);
            n_total++;
            if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, done} !==
                {1'b1, 1'b1, exp_addr, exp_wdata, exp_wstrb, 1'b0})
                $display("FAIL %s_req%0d: valid %b we %b addr %h wdata %h wstrb %b done %b expected 1 1 %h %h %b 0",
                         nm, i, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, done,
                         exp_addr, exp_wdata, exp_wstrb);
            else n_pass++;
            tick();
        end
        issue_valid   = 1'b0;
        mem_req_ready = 1'b0;
        n_total++;
        if ({mem_req_valid, done, err, reg_write_en, issue_ready} !== 5'b01001)
            $display("FAIL %s_done: valid %b done %b err %b wen %b ready %b expected 01001",
                     nm, mem_req_valid, done, err, reg_write_en, issue_ready);
        else n_pass++;
        tick();
        n_total++;
        if ({done, reg_write_en, mem_req_valid} !== 3'b000)
            $display("FAIL %s_after: done %b wen %b valid %b expected 000", nm, done, reg_write_en, mem_req_valid);
        else n_pass++;
    endtask

    task automatic run_bad(input string nm, input logic st, input logic [2:0] f3,
                           input logic [31:0] b, input logic [31:0] im, input logic [31:0] exp_ea);
        issue(st, f3, b, im, 5'd1, 5'd2, 32'h1111_2222);
        mem_req_ready = 1'b1;
        tick();  // T1
        issue_valid = 1'b0;
        n_total++;
        if ({mem_req_valid, done, err, issue_ready, err_addr} !== {4'b0111, exp_ea})
            $display("FAIL %s_err: valid %b done %b err %b ready %b err_addr %h expected 0 1 1 1 %h",
                     nm, mem_req_valid, done, err, issue_ready, err_addr, exp_ea);
        else n_pass++;
        tick();
        n_total++;
        if ({mem_req_valid, done, err, err_addr} !== {3'b000, exp_ea})
            $display("FAIL %s_hold: valid %b done %b err %b err_addr %h expected 0 0 0 %h",
                     nm, mem_req_valid, done, err, err_addr, exp_ea);
        else n_pass++;
    endtask

    task automatic test_loads();
        run_load("lw",  3'd2, 32'h100, 32'h4,        5'd5,  32'hDEADBEEF, 32'h104, 32'hDEADBEEF);
        run_load("lb",  3'd0, 32'h100, 32'h3,        5'd6,  32'h80123456, 32'h100, 32'hFFFFFF80);
        run_load("lbu", 3'd4, 32'h100, 32'h3,        5'd6,  32'h80123456, 32'h100, 32'h00000080);
        run_load("lh",  3'd1, 32'h100, 32'h2,        5'd8,  32'h80011234, 32'h100, 32'hFFFF8001);
        run_load("lhu", 3'd5, 32'h100, 32'h0,        5'd8,  32'h1234F00D, 32'h100, 32'h0000F00D);
        run_load("lbn", 3'd0, 32'h210, 32'hFFFFFFF1, 5'd31, 32'h00007F00, 32'h200, 32'h0000007F);
        run_load("rd0", 3'd2, 32'h100, 32'h0,        5'd0,  32'h12345678, 32'h100, 32'h12345678);
    endtask

    task automatic test_stores();
        run_store("sh", 3'd1, 32'h200, 32'h6, 32'h1234ABCD, 3, 32'h204, 32'hABCDABCD, 4'b1100);
        run_store("sb", 3'd0, 32'h300, 32'h1, 32'h12345678, 0, 32'h300, 32'h78787878, 4'b0010);
        run_store("sw", 3'd2, 32'h400, 32'h8, 32'hCAFEF00D, 1, 32'h408, 32'hCAFEF00D, 4'b1111);
    endtask

    task automatic test_errors();
        run_bad("lw_mis",  1'b0, 3'd2, 32'h100, 32'h2, 32'h102);
        run_bad("sh_mis",  1'b1, 3'd1, 32'h100, 32'h1, 32'h101);
        run_bad("ld_f3_3", 1'b0, 3'd3, 32'h0FC, 32'h4, 32'h100);
        run_bad("st_f3_4", 1'b1, 3'd4, 32'h500, 32'h0, 32'h500);
    endtask

    task automatic test_wb_block();
        issue(1'b0, 3'd2, 32'h600, 32'h0, 5'd0, 5'd7, 32'h0);
        mem_req_ready = 1'b1;
        tick();  // T1
        issue_valid = 1'b0;
        tick();  // T2
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        wb_block   = 1'b1;
        tick();  // T3, blocked
        mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if ({reg_write_en, done, issue_ready} !== 3'b000)
                $display("FAIL wbblk_%0d: wen %b done %b ready %b expected 000", i, reg_write_en, done, issue_ready);
            else n_pass++;
            if (i == 1) wb_block = 1'b0;
            #1;
            if (i == 0) tick();
        end
        n_total++;
        if ({reg_write_en, done, reg_write_addr, reg_write_data} !== {2'b11, 5'd7, 32'h55AA55AA})
            $display("FAIL wbblk_go: wen %b done %b waddr %0d wdata %h expected 1 1 7 55aa55aa",
                     reg_write_en, done, reg_write_addr, reg_write_data);
        else n_pass++;
        tick();
        n_total++;
        if ({reg_write_en, done, issue_ready} !== 3'b001)
            $display("FAIL wbblk_after: wen %b done %b ready %b expected 001", reg_write_en, done, issue_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        // reset while a request is pending: the request must drop without a clock edge
        issue(1'b0, 3'd2, 32'h700, 32'h0, 5'd0, 5'd4, 32'h0);
        mem_req_ready = 1'b0;
        tick();
        issue_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_total++;
        if ({mem_req_valid, mem_addr} !== 33'h0)
            $display("FAIL rst_req: valid %b addr %h expected 0 0", mem_req_valid, mem_addr);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        // reset in RWAIT, then a late rvalid
        issue(1'b0, 3'd2, 32'h700, 32'h0, 5'd0, 5'd4, 32'h0);
        mem_req_ready = 1'b1;
        tick();
        issue_valid = 1'b0;
        tick();  // RWAIT
        rst = 1'b1;
        #1;
        n_total++;
        if ({mem_req_valid, mem_we, reg_write_en, done, err, mem_addr, reg_write_addr, issue_ready} !==
            {5'b00000, 32'h0, 5'd0, 1'b1})
            $display("FAIL rst_rwait: valid %b we %b wen %b done %b err %b addr %h waddr %0d ready %b expected 0 0 0 0 0 0 0 1",
                     mem_req_valid, mem_we, reg_write_en, done, err, mem_addr, reg_write_addr, issue_ready);
        else n_pass++;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        tick();
        rst = 1'b0;
        tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if ({reg_write_en, done, mem_req_valid, issue_ready, reg_write_data} !== {4'b0001, 32'h0})
                $display("FAIL rst_late_%0d: wen %b done %b valid %b ready %b wdata %h expected 0 0 0 1 0",
                         i, reg_write_en, done, mem_req_valid, issue_ready, reg_write_data);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 3'd2, 32'h800, 32'h0, 5'd2, 5'd0, 32'h01020304);
        mem_req_ready = 1'b1;
        tick();  // T1: store handshake
        issue_valid = 1'b0;
        tick();  // T2: done, IDLE, accept load now
        n_total++;
        if ({done, issue_ready} !== 2'b11)
            $display("FAIL b2b_done: done %b ready %b expected 11", done, issue_ready);
        else n_pass++;
        issue(1'b0, 3'd0, 32'h900, 32'h5, 5'd0, 5'd10, 32'h0);
        tick();  // T3
        issue_valid = 1'b0;
        n_total++;
        if ({mem_req_valid, mem_we, done, mem_addr} !== {3'b100, 32'h904})
            $display("FAIL b2b_req: valid %b we %b done %b addr %h expected 1 0 0 904",
                     mem_req_valid, mem_we, done, mem_addr);
        else n_pass++;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000C300;
        tick();
        mem_rvalid = 1'b0;
        n_total++;
        if ({reg_write_en, done, reg_write_data} !== {2'b11, 32'hFFFFFFC3})
            $display("FAIL b2b_wb: wen %b done %b wdata %h expected 1 1 ffffffc3", reg_write_en, done, reg_write_data);
        else n_pass++;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0; base = 32'h0; imm = 32'h0;
        rs2_addr = 5'd0; rd_addr = 5'd0; reg_read_data = 32'h0; wb_block = 1'b0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_wb_block();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
